// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO moves and busy/done handshake.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_opA,
  input  logic [DATA_WIDTH-1:0] i_opB,
  input  logic                  i_mthi,
  input  logic                  i_mtlo,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_divzero
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic div_q, div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0] rem_q, rem_d;
  logic [W-1:0] abs_a, abs_b;
  logic [W:0] mul_sum;
  logic [W+1:0] div_sh;
  logic div_ge, start_dz;
  logic [2*W-1:0] prod;
  always_comb begin
    abs_a = (!i_op[0] && i_opA[W-1]) ? -i_opA : i_opA;
    abs_b = (!i_op[0] && i_opB[W-1]) ? -i_opB : i_opB;
    start_dz = i_op[1] && (i_opB == '0);
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // dividend bits shift out of the low half of acc into the partial remainder
    div_sh = {rem_q, acc_q[W-1]};
    div_ge = div_sh >= (W+2)'(opnd_q);
    prod = (sgn_q && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    state_d = state_q;
    div_d = div_q;
    sgn_d = sgn_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    cnt_d = cnt_q;
    opnd_d = opnd_q;
    acc_d = acc_q;
    rem_d = rem_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    divzero_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_start) begin
        div_d = i_op[1];
        sgn_d = !i_op[0];
        sa_d = !i_op[0] && i_opA[W-1];
        sb_d = !i_op[0] && i_opB[W-1];
        dz_d = start_dz;
        cnt_d = '0;
        opnd_d = i_op[1] ? abs_b : abs_a;
        acc_d = {{W{1'b0}}, i_op[1] ? abs_a : abs_b};
        rem_d = '0;
        state_d = start_dz ? FIX : RUN;
      end else begin
        hi_d = i_mthi ? i_wdata : hi_q;
        lo_d = i_mtlo ? i_wdata : lo_q;
      end
    end else if (state_q == RUN) begin
      rem_d = div_q ? (div_ge ? (W+1)'(div_sh - (W+2)'(opnd_q)) : div_sh[W:0]) : rem_q;
      acc_d = div_q ? {acc_q[2*W-1:W], acc_q[W-2:0], div_ge} : {mul_sum, acc_q[W-1:1]};
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? FIX : RUN;
    end else begin
      state_d = IDLE;
      done_d = 1'b1;
      divzero_d = dz_q;
      if (!dz_q) begin
        hi_d = div_q ? ((sgn_q && sa_q) ? -rem_q[W-1:0] : rem_q[W-1:0]) : prod[2*W-1:W];
        lo_d = div_q ? ((sgn_q && (sa_q ^ sb_q)) ? -acc_q[W-1:0] : acc_q[W-1:0]) : prod[W-1:0];
      end
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      cnt_q <= '0;
      opnd_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      sgn_q <= sgn_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      dz_q <= dz_d;
      cnt_q <= cnt_d;
      opnd_q <= opnd_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      divzero_q <= divzero_d;
    end
  end
  assign o_hi = hi_q;
  assign o_lo = lo_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_divzero = divzero_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_start = 1'b0;
  logic [1:0] i_op = 2'd0;
  logic [31:0] i_opA = '0, i_opB = '0, i_wdata = '0;
  logic i_mthi = 1'b0, i_mtlo = 1'b0;
  logic [31:0] o_hi, o_lo;
  logic o_busy, o_done, o_divzero;
  int checks = 0, errors = 0;
  logic [31:0] mhi = '0, mlo = '0;
  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_opA(i_opA), .i_opB(i_opB), .i_mthi(i_mthi), .i_mtlo(i_mtlo), .i_wdata(i_wdata),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done), .o_divzero(o_divzero)
  );
  always #5 i_clock = ~i_clock;
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up, ua, ub;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = '0;
    l = '0;
    if (op == 2'd0) begin
      sp = sa * sb;
      h = sp[63:32];
      l = sp[31:0];
    end else if (op == 2'd1) begin
      up = ua * ub;
      h = up[63:32];
      l = up[31:0];
    end else if (op == 2'd2) begin
      sq = sa / sb;
      sr = sa % sb;
      l = sq[31:0];
      h = sr[31:0];
    end else begin
      up = ua / ub;
      l = up[31:0];
      up = ua % ub;
      h = up[31:0];
    end
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic mv);
    logic [31:0] eh, el;
    logic dz;
    int cyc, bn, lat;
    dz = op[1] && (b == 32'd0);
    if (dz) begin
      eh = mhi;
      el = mlo;
    end else model(op, a, b, eh, el);
    lat = dz ? 1 : 33;
    i_op = op; i_opA = a; i_opB = b; i_start = 1'b1; i_mtlo = mv; i_wdata = 32'hcafef00d;
    @(posedge i_clock); #1;
    i_start = 1'b0; i_mtlo = 1'b0;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL launch op=%0d done=%b busy=%b want done=0 busy=1", op, o_done, o_busy);
    end
    bn = o_busy ? 1 : 0;
    cyc = 0;
    while (!o_done && cyc < 100) begin
      @(posedge i_clock); #1;
      cyc++;
      if (o_busy) bn++;
    end
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("FAIL latency op=%0d a=%h b=%h got %0d want %0d", op, a, b, cyc, lat);
    end
    checks++;
    if (bn !== lat) begin
      errors++;
      $display("FAIL busy_len op=%0d a=%h b=%h got %0d want %0d", op, a, b, bn, lat);
    end
    checks++;
    if (o_hi !== eh || o_lo !== el) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", op, a, b, o_hi, o_lo, eh, el);
    end
    checks++;
    if (o_divzero !== dz) begin
      errors++;
      $display("FAIL divzero op=%0d a=%h b=%h got %b want %b", op, a, b, o_divzero, dz);
    end
    mhi = eh;
    mlo = el;
  endtask
  task automatic do_move(input logic hw, input logic lw, input logic [31:0] d);
    i_mthi = hw; i_mtlo = lw; i_wdata = d;
    @(posedge i_clock); #1;
    i_mthi = 1'b0; i_mtlo = 1'b0;
    if (hw) mhi = d;
    if (lw) mlo = d;
    checks++;
    if (o_hi !== mhi || o_lo !== mlo) begin
      errors++;
      $display("FAIL move got hi=%h lo=%h want hi=%h lo=%h", o_hi, o_lo, mhi, mlo);
    end
  endtask
  task automatic test_reset;
    i_reset = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    checks++;
    if ({o_hi, o_lo, o_busy, o_done, o_divzero} !== 67'd0) begin
      errors++;
      $display("FAIL reset got hi=%h lo=%h busy=%b done=%b dz=%b want all 0", o_hi, o_lo, o_busy, o_done, o_divzero);
    end
    i_reset = 1'b0;
    mhi = '0;
    mlo = '0;
  endtask
  task automatic test_directed;
    run_op(2'd1, 32'hffffffff, 32'hffffffff, 1'b0);
    run_op(2'd0, 32'hfffffffd, 32'd7, 1'b0);
    run_op(2'd0, 32'h80000000, 32'h80000000, 1'b0);
    run_op(2'd2, 32'hfffffff9, 32'd2, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd2, 32'h80000000, 32'hffffffff, 1'b0);
    checks++;
    if (o_lo !== 32'h80000000 || o_hi !== 32'h0) begin
      errors++;
      $display("FAIL div_overflow got hi=%h lo=%h want hi=00000000 lo=80000000", o_hi, o_lo);
    end
  endtask
  task automatic test_divzero;
    do_move(1'b1, 1'b0, 32'h1234);
    do_move(1'b0, 1'b1, 32'h5678);
    run_op(2'd3, 32'd5, 32'd0, 1'b0);
    run_op(2'd2, 32'hffffff00, 32'd0, 1'b0);
    do_move(1'b1, 1'b1, 32'h0badf00d);
  endtask
  task automatic test_ignored;
    logic [31:0] eh, el;
    int cyc;
    model(2'd1, 32'h12345678, 32'h9abcdef0, eh, el);
    i_op = 2'd1; i_opA = 32'h12345678; i_opB = 32'h9abcdef0; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clock);
    #1;
    i_op = 2'd2; i_opA = 32'h1111; i_opB = 32'h3; i_start = 1'b1; i_mthi = 1'b1; i_wdata = 32'hdeadbeef;
    @(posedge i_clock); #1;
    i_start = 1'b0; i_mthi = 1'b0;
    cyc = 6;
    while (!o_done && cyc < 100) begin
      @(posedge i_clock); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 33 || o_hi !== eh || o_lo !== el) begin
      errors++;
      $display("FAIL ignore_busy got cyc=%0d hi=%h lo=%h want cyc=33 hi=%h lo=%h", cyc, o_hi, o_lo, eh, el);
    end
    mhi = eh;
    mlo = el;
    run_op(2'd1, 32'd3, 32'd5, 1'b1);
  endtask
  task automatic test_random;
    logic [1:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 7) == 0) b = 32'hffffffff;
      else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
      run_op(op, a, b, 1'b0);
    end
  endtask
  task automatic test_reset_mid;
    do_move(1'b1, 1'b1, 32'h55aa55aa);
    i_op = 2'd1; i_opA = 32'hffff0000; i_opB = 32'h0000ffff; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clock);
    #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_hi, o_lo, o_busy, o_done, o_divzero} !== 67'd0) begin
      errors++;
      $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b dz=%b want all 0", o_hi, o_lo, o_busy, o_done, o_divzero);
    end
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    mhi = '0;
    mlo = '0;
    run_op(2'd3, 32'd9, 32'd3, 1'b0);
  endtask
  initial begin
    test_reset;
    test_directed;
    test_divzero;
    test_ignored;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the EX stage. It takes the two register operands that the ID/EX pipeline register latches from the decoder, and it computes 64-bit products and 32-bit quotient/remainder into the architectural HI/LO registers. While an operation is in flight it asserts `o_busy`, which the hazard/stall logic uses to freeze IF/ID and ID/EX. HI/LO are readable at all times for MFHI/MFLO and writable for MTHI/MTLO.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and HI/LO width; the iteration count equals `DATA_WIDTH`.

Ports:
- `i_clock` in 1: the single clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_start` in 1: launch the operation in `i_op`; sampled only in IDLE.
- `i_op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `i_opA` in DATA_WIDTH: rs value (dividend / multiplicand).
- `i_opB` in DATA_WIDTH: rt value (divisor / multiplier).
- `i_mthi` in 1: write `i_wdata` to HI.
- `i_mtlo` in 1: write `i_wdata` to LO.
- `i_wdata` in DATA_WIDTH: MTHI/MTLO data.
- `o_hi` out DATA_WIDTH: HI register.
- `o_lo` out DATA_WIDTH: LO register.
- `o_busy` out 1: registered; high while state ≠ IDLE.
- `o_done` out 1: one-cycle pulse when HI/LO take a result.
- `o_divzero` out 1: pulses with `o_done` when a DIV/DIVU had `i_opB` == 0.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE, with `i_start`:**
  - The unit latches the op, the signedness and the operands.
  - For signed ops it latches absolute values and records sign bits. abs(0x80000000) = 0x80000000 as unsigned.
  - The iteration counter is cleared and the state goes to RUN.
  - If the op is DIV/DIVU and `i_opB` == 0, the state goes to FIX directly with a divzero flag set.
- **IDLE, without `i_start`:** `i_mthi`/`i_mtlo` write HI/LO at the edge. Both may be asserted together.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, into a 2·DATA_WIDTH accumulator.
- **RUN, divide:** restoring division, one quotient bit per cycle; the remainder register is DATA_WIDTH+1 bits to hold the trial subtraction.
- **RUN exit:** after DATA_WIDTH iterations (counter reaches DATA_WIDTH−1 and that iteration completes), the state goes to FIX.
- **FIX:**
  - Multiply, signed: if signA≠signB, negate the 64-bit product (two's complement). Then HI = upper half, LO = lower half.
  - Divide, signed: the quotient is negated if signA≠signB, and the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - Divide by zero: HI/LO unchanged and `o_divzero` pulses.
  - In every case the state returns to IDLE and `o_done` pulses.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the quotient wraps to 0x80000000 and the remainder is 0. No exception is raised.
- **Ignored inputs:**
  - `i_start` in RUN/FIX is ignored.
  - `i_mthi`/`i_mtlo` in RUN/FIX are ignored; the stall logic guarantees none are issued.
  - In IDLE, `i_start` together with `i_mthi`/`i_mtlo`: start wins, and the move is ignored.
- HI/LO change only on FIX completion (non-zero-divide), on a move, or on reset.

## Timing
- **Reset** (asynchronous, immediate on `i_reset` high, including mid-operation):
  - state IDLE, HI = LO = 0;
  - `o_busy` = `o_done` = `o_divzero` = 0;
  - counter and accumulators cleared.
- **Normal operation:** start is sampled at edge E0.
  - `o_busy` is high from E0 through E(DATA_WIDTH+1): 33 cycles at DATA_WIDTH = 32.
  - HI/LO update and `o_done` rise at E(DATA_WIDTH+1); `o_done` falls one cycle later.
  - A new start is accepted at the next edge after `o_done`.
- **Divide by zero:** start at E0, FIX at E0→E1, `o_done`/`o_divzero` after E1. `o_busy` is high for 1 cycle.
- **Moves:** HI/LO reflect a move at the edge it is sampled (1-cycle latency).
- `o_hi`/`o_lo` are driven directly from registers, with no combinational path from inputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `o_done` exactly 33 cycles after the start edge, and `o_busy` high for 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000. DIVU 5 / 0 after MTHI 0x1234 and MTLO 0x5678 → `o_done` and `o_divzero` one cycle after the start edge, HI/LO stay 0x1234/0x5678.
- Start a MULTU, then:
  - assert `i_start` with different operands and `i_mthi` at iteration 5 → both ignored, original result delivered;
  - in IDLE, assert `i_start` and `i_mtlo` together → only the multiply occurs.
- Assert `i_reset` asynchronously (mid-cycle) at iteration 10 → outputs immediately 0, state IDLE. A fresh DIVU 9/3 after release → LO=3, HI=0 in 33 cycles.
